// File: rtl/interval_tick_timer.sv
// Prescaled down-counting interval timer; emits a one-cycle tick that sets the
// downstream interrupt SR flop, and flags ticks that land on a pending interrupt.
//
//   state | meaning
//   IDLE  | counter held, prescaler parked, waiting for start
//   RUN   | prescaler advancing, counter stepping toward terminal count
module interval_tick_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             one_shot,
  input  logic             irq_pending,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             overrun
);

  localparam int             PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PMAX = PW'(PRESCALE - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic [PW-1:0]    presc, presc_n;
  logic             tick_q, tick_n;
  logic             ovr, ovr_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      reload <= '0;
      presc  <= '0;
      tick_q <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      reload <= reload_n;
      presc  <= presc_n;
      tick_q <= tick_n;
      ovr    <= ovr_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    reload_n = reload;
    presc_n  = presc;
    tick_n   = 1'b0;
    ovr_n    = ovr;

    if (load) begin
      reload_n = load_val;
      cnt_n    = load_val;
      presc_n  = '0;
      ovr_n    = 1'b0;
      // a start in the same cycle is judged against the value being loaded
      if (state == IDLE && start && load_val != '0) begin
        state_n = RUN;
      end
    end else if (stop && state == RUN) begin
      state_n = IDLE;
      presc_n = '0;
    end else if (start && state == IDLE) begin
      if (reload != '0) begin
        state_n = RUN;
        presc_n = '0;
        cnt_n   = reload;
      end
    end else if (state == RUN) begin
      if (presc == PMAX) begin
        presc_n = '0;
        if (cnt > WIDTH'(1)) begin
          cnt_n = cnt - WIDTH'(1);
        end else if (cnt == WIDTH'(1)) begin
          cnt_n  = reload;
          tick_n = 1'b1;
          if (irq_pending) ovr_n = 1'b1;
          if (one_shot) state_n = IDLE;
        end else begin
          // count of zero only follows a load of 0: park without ticking
          state_n = IDLE;
        end
      end else begin
        presc_n = presc + PW'(1);
      end
    end
  end

  assign tick    = tick_q;
  assign count   = cnt;
  assign running = (state == RUN);
  assign overrun = ovr;

endmodule

// File: doc/interval_tick_timer.md
Name: interval_tick_timer

Overview:
- Programmable interval timer that produces the one-cycle set pulse for the interrupt SR flop. The pulse drives the flop's S input, and the flop's Q feeds the processor interrupt line.
- The processor loads a reload value and starts or stops the timer through port-write strobes.
- The timer counts down in prescaled steps and emits `tick` at each terminal count. It flags an overrun when a tick lands while the previous interrupt is still pending.

Parameters:
- WIDTH, 16, width of the reload register and the down-counter.
- PRESCALE, 50000, clk cycles per counter step; legal range is 1 to 2^24. The prescaler width is derived internally from PRESCALE.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle strobe; captures load_val.
- load_val  input  WIDTH  reload value, sampled when load=1.
- start  input  1  one-cycle strobe; requests IDLE->RUN.
- stop  input  1  one-cycle strobe; requests RUN->IDLE.
- one_shot  input  1  level; 1 returns the timer to IDLE after the next tick.
- irq_pending  input  1  Q of the downstream SR flop.
- tick  output  1  registered one-cycle pulse; connects to the SR flop S input.
- count  output  WIDTH  current down-counter value.
- running  output  1  1 while in RUN.
- overrun  output  1  sticky flag: a tick was issued while irq_pending=1.

Behaviour:
- Reset (async, immediate) clears everything: count=0, reload=0, prescaler=0, tick=0, running=0, overrun=0, state=IDLE.
  - Reset asserted mid-run aborts the run with no tick.
- The FSM has two states, IDLE and RUN. running=1 exactly when state=RUN.
- Per-edge priority is load > stop > start > step.
- load (either state):
  - reload<=load_val, count<=load_val, prescaler<=0, overrun<=0.
  - No step that edge. State is unchanged.
  - load with start in IDLE: start is evaluated against load_val, and the timer enters RUN if load_val!=0.
- stop:
  - In RUN: go to IDLE, prescaler<=0, count held, no step or tick that edge (stop beats a coinciding terminal step).
  - In IDLE: ignored.
- start:
  - In IDLE with reload!=0: go to RUN, prescaler<=0, count<=reload.
  - In IDLE with reload==0: ignored; stays IDLE.
  - In RUN: ignored.
- Prescaling in RUN: the prescaler increments every cycle. When prescaler==PRESCALE-1, it resets to 0 and a step occurs. PRESCALE=1 gives a step every cycle.
- Step:
  - count>1: count<=count-1.
  - count==1 (terminal):
    - count<=reload and tick<=1.
    - If one_shot=1, go to IDLE. Otherwise stay in RUN (periodic mode).
- Timing:
  - tick is high for exactly one cycle after the terminal edge, and low on every other edge.
  - If start is sampled at edge E0 with reload=N, the terminal step is edge E0+N*PRESCALE, and the period thereafter is N*PRESCALE cycles.
- count never underflows or wraps; 0 occurs only after reset or a load of 0.
  - A load of 0 while in RUN: the next step sees count==0. The timer then goes to IDLE with no tick and count=0.
- Overrun: on a terminal step, overrun<=1 if irq_pending=1 on that same edge. overrun is sticky until load or reset. The tick is still issued.
- one_shot is sampled only at the terminal step; changing it mid-count has no other effect.

Test Plan:
- PRESCALE=4, reset, load 3, start at E0 -> running=1; count 3->2->1 at E0+4 and E0+8; tick high for the one cycle after E0+12; count=3 again; period 12 cycles thereafter.
- one_shot=1, PRESCALE=1, load 2, start -> single tick 2 cycles after start, running=0, count=2; no further ticks over 20 cycles.
- stop asserted on the exact terminal edge -> no tick, running=0, count=1 held; a later start reloads count=reload and times a full period.
- irq_pending held 1 while periodic with load 2, PRESCALE=1 -> first tick sets overrun=1, ticks continue; load 5 clears overrun=0 and count=5.
- start with reload=0 -> stays IDLE. Simultaneous load 4 + start -> RUN with count=4. Load 0 mid-run -> IDLE with no tick.
- Assert reset mid-count (count=7, prescaler mid-way) -> all outputs 0 asynchronously before the next edge; no tick after release.
